// File: rtl/resize_accel_udiv_32ns_16ns_seq_pkg.sv
// Shared types and default sizing for the sequential 32/16 unsigned divider.
package resize_accel_udiv_32ns_16ns_seq_pkg;

    localparam int unsigned DefDividendW = 32;
    localparam int unsigned DefDivisorW  = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter must be able to hold the full iteration count, not just count-1.
    function automatic int unsigned cnt_width(input int unsigned dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

    localparam int unsigned DefCntW = cnt_width(DefDividendW);

endpackage

// File: rtl/resize_accel_udiv_32ns_16ns_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
interface resize_accel_udiv_32ns_16ns_seq_if
    import resize_accel_udiv_32ns_16ns_seq_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DefDividendW,
    parameter int unsigned DIVISOR_W  = DefDivisorW
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] din0;
    logic [DIVISOR_W-1:0]  din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] quot;
    logic [DIVISOR_W-1:0]  rem;
    logic                  div_zero;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, quot, rem, div_zero
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, quot, rem, div_zero
    );

endinterface

// File: rtl/resize_accel_udiv_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract, restore.
module resize_accel_udiv_step #(
    parameter int unsigned DIVISOR_W = 16
) (
    input  logic [DIVISOR_W:0]   rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W:0]   rem_o,
    output logic                 quot_bit_o
);

    logic [DIVISOR_W:0]   shifted;
    logic [DIVISOR_W+1:0] diff;

    // A set rem_i MSB means the true shifted value exceeds any divisor (only
    // reachable with a zero divisor), so the quotient bit is forced to one.
    always_comb begin
        shifted    = {rem_i[DIVISOR_W-1:0], bit_i};
        diff       = {1'b0, shifted} - {2'b00, divisor_i};
        quot_bit_o = rem_i[DIVISOR_W] | ~diff[DIVISOR_W+1];
        rem_o      = quot_bit_o ? diff[DIVISOR_W:0] : shifted;
    end

endmodule

// File: rtl/resize_accel_udiv_32ns_16ns_seq.sv
// Sequential unsigned divider: one quotient bit per enabled clock, MSB first.
module resize_accel_udiv_32ns_16ns_seq
    import resize_accel_udiv_32ns_16ns_seq_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DefDividendW,
    parameter int unsigned DIVISOR_W  = DefDivisorW
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    resize_accel_udiv_32ns_16ns_seq_if.slave bus
);

    localparam int unsigned     CntW    = cnt_width(DIVIDEND_W);
    localparam logic [CntW-1:0] LastCnt = CntW'(DIVIDEND_W - 1);

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [DIVIDEND_W-1:0] dividend_q;
    logic [DIVISOR_W-1:0]  divisor_q;
    logic [DIVISOR_W:0]    part_rem_q;
    logic [DIVIDEND_W-1:0] quot_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic                  div_zero_q;
    logic                  in_ready_q;
    logic                  out_valid_q;

    logic [DIVISOR_W:0]    step_rem;
    logic                  step_bit;
    logic [DIVIDEND_W-1:0] quot_next;

    resize_accel_udiv_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_i      (part_rem_q),
        .bit_i      (dividend_q[DIVIDEND_W-1]),
        .divisor_i  (divisor_q),
        .rem_o      (step_rem),
        .quot_bit_o (step_bit)
    );

    // Dividend register doubles as the quotient shift register.
    assign quot_next = {dividend_q[DIVIDEND_W-2:0], step_bit};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            part_rem_q  <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            div_zero_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (ce) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        dividend_q <= bus.din0;
                        divisor_q  <= bus.din1;
                        part_rem_q <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StCalc;
                    end
                end
                StCalc: begin
                    part_rem_q <= step_rem;
                    dividend_q <= quot_next;
                    cnt_q      <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        quot_q      <= quot_next;
                        rem_q       <= step_rem[DIVISOR_W-1:0];
                        div_zero_q  <= (divisor_q == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quot      = quot_q;
    assign bus.rem       = rem_q;
    assign bus.div_zero  = div_zero_q;

    a_ready_valid_excl: assert property (@(posedge clk) disable iff (!reset_n)
        !(in_ready_q && out_valid_q));

    a_result_held: assert property (@(posedge clk) disable iff (!reset_n)
        (out_valid_q && !(ce && bus.out_ready)) |=>
            (out_valid_q && $stable(quot_q) && $stable(rem_q) && $stable(div_zero_q)));

endmodule

// File: tb/tb_resize_accel_udiv_32ns_16ns_seq.sv
// Scoreboard bench: driver pushes expected results, monitor pops on each out_valid rise.
module tb_resize_accel_udiv_32ns_16ns_seq;

    typedef struct {
        logic [31:0] q;
        logic [15:0] r;
        logic        z;
        int          acc;
        int          lat;
    } exp_t;

    logic clk;
    logic reset_n;
    logic ce;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    resize_accel_udiv_32ns_16ns_seq_if bus_if ();

    resize_accel_udiv_32ns_16ns_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    // Present operands once the block is idle; expectation carries the acceptance cycle.
    task automatic issue(input logic [31:0] a, input logic [15:0] b, input logic [31:0] eq,
                         input logic [15:0] er, input logic ez, input int lat);
        int   t = 0;
        exp_t e;
        while (bus_if.in_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (bus_if.in_ready !== 1'b1) begin
            chk("issue_wait_ready", {31'b0, bus_if.in_ready}, 32'd1);
            return;
        end
        bus_if.din0     = a;
        bus_if.din1     = b;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        chk("accept_in_ready_low", {31'b0, bus_if.in_ready}, 32'd0);
        e.q   = eq;
        e.r   = er;
        e.z   = ez;
        e.acc = cyc;
        e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (bus_if.in_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("wait_idle", {31'b0, bus_if.in_ready}, 32'd1);
    endtask

    // Monitor: compare on each out_valid rise, then check the held result stays put.
    initial begin
        logic        prev_ov = 1'b0;
        logic [31:0] hq      = '0;
        logic [15:0] hr      = '0;
        logic        hz      = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (bus_if.out_valid === 1'b1 && !prev_ov) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("quot", bus_if.quot, e.q);
                    chk("rem", {16'b0, bus_if.rem}, {16'b0, e.r});
                    chk("div_zero", {31'b0, bus_if.div_zero}, {31'b0, e.z});
                    chk("latency", cyc - e.acc, e.lat);
                end
                hq = bus_if.quot;
                hr = bus_if.rem;
                hz = bus_if.div_zero;
            end else if (bus_if.out_valid === 1'b1 && prev_ov) begin
                chk("hold_quot", bus_if.quot, hq);
                chk("hold_rem", {16'b0, bus_if.rem}, {16'b0, hr});
                chk("hold_div_zero", {31'b0, bus_if.div_zero}, {31'b0, hz});
                chk("hold_in_ready", {31'b0, bus_if.in_ready}, 32'd0);
            end
            prev_ov = (bus_if.out_valid === 1'b1);
        end
    end

    initial begin
        int t;
        reset_n          = 1'b1;
        ce               = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        bus_if.din0      = '0;
        bus_if.din1      = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, bus_if.in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, bus_if.out_valid}, 32'd0);
        chk("rst_quot", bus_if.quot, 32'd0);
        chk("rst_rem", {16'b0, bus_if.rem}, 32'd0);
        chk("rst_div_zero", {31'b0, bus_if.div_zero}, 32'd0);
        reset_n = 1'b1;

        // Directed vectors, accepted on the first edge after release.
        issue(32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 32);
        issue(32'hFFFF_FFFF, 16'd1, 32'hFFFF_FFFF, 16'd0, 1'b0, 32);
        issue(32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'd0, 1'b0, 32);
        issue(32'h1234_5678, 16'd0, 32'hFFFF_FFFF, 16'h5678, 1'b1, 32);
        issue(32'd7, 16'd100, 32'd0, 16'd7, 1'b0, 32);
        issue(32'h8000_0000, 16'd2, 32'h4000_0000, 16'd0, 1'b0, 32);
        issue(32'hFFFF_FFFF, 16'h8000, 32'h0001_FFFF, 16'h7FFF, 1'b0, 32);
        issue(32'd0, 16'd0, 32'hFFFF_FFFF, 16'd0, 1'b1, 32);

        // Consumer stalls in DONE while a new operand is offered.
        wait_idle();
        bus_if.out_ready = 1'b0;
        issue(32'd50, 16'd5, 32'd10, 16'd0, 1'b0, 32);
        t = 0;
        while (bus_if.out_valid !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("hold_reached_done", {31'b0, bus_if.out_valid}, 32'd1);
        bus_if.din0     = 32'd123;
        bus_if.din1     = 16'd4;
        bus_if.in_valid = 1'b1;
        repeat (10) @(negedge clk);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk("post_hold_in_ready", {31'b0, bus_if.in_ready}, 32'd1);
        chk("post_hold_out_valid", {31'b0, bus_if.out_valid}, 32'd0);

        // Clock enable dropped for 5 cycles mid-calculation.
        issue(32'd1000, 16'd33, 32'd30, 16'd10, 1'b0, 37);
        repeat (10) @(posedge clk);
        #1 ce = 1'b0;
        repeat (5) @(posedge clk);
        #1 ce = 1'b1;

        // Reset at iteration 16 discards the operation.
        wait_idle();
        issue(32'h0000_DEAD, 16'h0011, 32'd0, 16'd0, 1'b0, 32);
        repeat (16) @(posedge clk);
        #1 reset_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_in_ready", {31'b0, bus_if.in_ready}, 32'd1);
        chk("midrst_out_valid", {31'b0, bus_if.out_valid}, 32'd0);
        chk("midrst_quot", bus_if.quot, 32'd0);
        chk("midrst_rem", {16'b0, bus_if.rem}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        issue(32'd9, 16'd3, 32'd3, 16'd0, 1'b0, 32);

        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_scoreboard", sb.size(), 32'd0);
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
